// File: rtl/frame_deserializer.sv
// Purpose: rebuild 12-bit words from the extractor's serial readout link, tag them with
//          their frame index, extract RTC min/sec and report each completed frame's peak channel.
// Latency: word_valid rises on the edge that samples the LSB. No backpressure: the link runs freely.
//
// Ports:
//   clk, reset      readout clock (rising edge), asynchronous active-low reset
//   serial_in       serial data, MSB first
//   sl_in           shift/load strobe (1 = load, 0 = shift)
//   frame_sync      1-cycle pulse, restarts the frame at word index 0
//   word_data/word_idx/word_valid   last completed word, its index, 1-cycle strobe
//   frame_done      1-cycle strobe with the last word of a frame
//   rtc_min/rtc_sec fields of the last completed word 0
//   peak_idx/peak_val   highest channel of the last completed frame
//   short_err       sticky flag: a word was cut short by an early load
module frame_deserializer #(
   parameter int WORD_W  = 12,
   parameter int N_WORDS = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              sl_in,
   input  logic              frame_sync,
   output logic [WORD_W-1:0] word_data,
   output logic [3:0]        word_idx,
   output logic              word_valid,
   output logic              frame_done,
   output logic [5:0]        rtc_min,
   output logic [5:0]        rtc_sec,
   output logic [3:0]        peak_idx,
   output logic [WORD_W-1:0] peak_val,
   output logic              short_err
);

   typedef enum logic [1:0] {IDLE, ARMED, SHIFT, HOLD} state_t;

   localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);
   localparam logic [3:0] LAST_IDX = 4'(N_WORDS - 1);

   state_t            state_q, state_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [3:0]        idx_q, idx_d;
   logic [WORD_W-1:0] word_data_q, word_data_d;
   logic [3:0]        word_idx_q, word_idx_d;
   logic              word_valid_q, word_valid_d;
   logic              frame_done_q, frame_done_d;
   logic [5:0]        rtc_min_q, rtc_min_d;
   logic [5:0]        rtc_sec_q, rtc_sec_d;
   logic [3:0]        peak_idx_q, peak_idx_d;
   logic [WORD_W-1:0] peak_val_q, peak_val_d;
   logic              short_err_q, short_err_d;
   logic [WORD_W-1:0] run_max_q, run_max_d;
   logic [3:0]        run_idx_q, run_idx_d;

   // combinational helpers
   logic              complete;
   logic              short_set;
   logic [WORD_W-1:0] new_word;
   logic [WORD_W-1:0] cmp_max;
   logic [3:0]        cmp_idx;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      idx_d        = idx_q;
      word_data_d  = word_data_q;
      word_idx_d   = word_idx_q;
      word_valid_d = 1'b0;
      frame_done_d = 1'b0;
      rtc_min_d    = rtc_min_q;
      rtc_sec_d    = rtc_sec_q;
      peak_idx_d   = peak_idx_q;
      peak_val_d   = peak_val_q;
      short_err_d  = short_err_q;
      run_max_d    = run_max_q;
      run_idx_d    = run_idx_q;
      complete     = 1'b0;
      short_set    = 1'b0;
      new_word     = {shreg_q[WORD_W-2:0], serial_in};
      cmp_max      = run_max_q;
      cmp_idx      = run_idx_q;

      case (state_q)
         IDLE: begin
            if (sl_in) state_d = ARMED;
         end
         ARMED: begin
            if (!sl_in) begin
               // first sampled bit lands in the LSB and is shifted up to the MSB by the end
               shreg_d   = {{(WORD_W-1){1'b0}}, serial_in};
               bit_cnt_d = 4'd1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (sl_in) begin
               // early load: drop the partial word, index stays where it was
               short_set   = 1'b1;
               short_err_d = 1'b1;
               bit_cnt_d   = 4'd0;
               state_d     = ARMED;
            end else begin
               shreg_d   = new_word;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  complete  = 1'b1;
                  bit_cnt_d = 4'd0;
                  state_d   = HOLD;
               end
            end
         end
         HOLD: begin
            if (sl_in) state_d = ARMED;
         end
         default: state_d = IDLE;
      endcase

      if (complete) begin
         word_data_d  = new_word;
         word_idx_d   = idx_q;
         word_valid_d = 1'b1;
         idx_d        = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
         if (idx_q == 4'd0) begin
            rtc_min_d = new_word[WORD_W-1 -: 6];
            rtc_sec_d = new_word[5:0];
         end else begin
            // strictly greater, so a tie keeps the earlier (lower) channel
            if (new_word > run_max_q) begin
               cmp_max = new_word;
               cmp_idx = idx_q;
            end
            run_max_d = cmp_max;
            run_idx_d = cmp_idx;
            if (idx_q == LAST_IDX) begin
               frame_done_d = 1'b1;
               peak_val_d   = cmp_max;
               peak_idx_d   = cmp_idx;
               run_max_d    = '0;
               run_idx_d    = 4'd0;
            end
         end
      end

      // applied last so it overrides the index advance of a coincident word
      if (frame_sync) begin
         idx_d     = 4'd0;
         run_max_d = '0;
         run_idx_d = 4'd0;
         if (!short_set) short_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 4'd0;
         shreg_q      <= '0;
         idx_q        <= 4'd0;
         word_data_q  <= '0;
         word_idx_q   <= 4'd0;
         word_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         rtc_min_q    <= 6'd0;
         rtc_sec_q    <= 6'd0;
         peak_idx_q   <= 4'd0;
         peak_val_q   <= '0;
         short_err_q  <= 1'b0;
         run_max_q    <= '0;
         run_idx_q    <= 4'd0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         idx_q        <= idx_d;
         word_data_q  <= word_data_d;
         word_idx_q   <= word_idx_d;
         word_valid_q <= word_valid_d;
         frame_done_q <= frame_done_d;
         rtc_min_q    <= rtc_min_d;
         rtc_sec_q    <= rtc_sec_d;
         peak_idx_q   <= peak_idx_d;
         peak_val_q   <= peak_val_d;
         short_err_q  <= short_err_d;
         run_max_q    <= run_max_d;
         run_idx_q    <= run_idx_d;
      end
   end

   assign word_data  = word_data_q;
   assign word_idx   = word_idx_q;
   assign word_valid = word_valid_q;
   assign frame_done = frame_done_q;
   assign rtc_min    = rtc_min_q;
   assign rtc_sec    = rtc_sec_q;
   assign peak_idx   = peak_idx_q;
   assign peak_val   = peak_val_q;
   assign short_err  = short_err_q;

endmodule
